// File: rtl/thor2023_cond_resolve_if.sv
// Handshake and result bus for the thor2023 condition-resolve stage.
// slave = the resolve stage itself, master = the side driving operations into it.
interface thor2023_cond_resolve_if #(
    parameter int PCW  = 32,
    parameter int TAGW = 5
);
    logic            in_v_i;
    logic            in_rdy_o;
    logic [15:0]     cmp_i;
    logic [3:0]      cond_i;
    logic            inv_i;
    logic            br_i;
    logic            pred_taken_i;
    logic [PCW-1:0]  tgt_i;
    logic [PCW-1:0]  nxt_pc_i;
    logic [TAGW-1:0] tag_i;
    logic            out_v_o;
    logic            out_rdy_i;
    logic [TAGW-1:0] out_tag_o;
    logic            out_cond_o;
    logic            out_br_o;
    logic            out_misp_o;
    logic            redirect_o;
    logic [PCW-1:0]  redirect_pc_o;
    logic            flush_done_i;
    logic [31:0]     stat_br_o;
    logic [31:0]     stat_misp_o;

    modport slave (
        input  in_v_i, cmp_i, cond_i, inv_i, br_i, pred_taken_i, tgt_i, nxt_pc_i, tag_i,
        input  out_rdy_i, flush_done_i,
        output in_rdy_o, out_v_o, out_tag_o, out_cond_o, out_br_o, out_misp_o,
        output redirect_o, redirect_pc_o, stat_br_o, stat_misp_o
    );

    modport master (
        output in_v_i, cmp_i, cond_i, inv_i, br_i, pred_taken_i, tgt_i, nxt_pc_i, tag_i,
        output out_rdy_i, flush_done_i,
        input  in_rdy_o, out_v_o, out_tag_o, out_cond_o, out_br_o, out_misp_o,
        input  redirect_o, redirect_pc_o, stat_br_o, stat_misp_o
    );
endinterface

// File: rtl/thor2023_cond_resolve.sv
// Condition-resolve stage: selects a compare bit, resolves branches/predicate sets into a
// 2-entry result FIFO, and flushes after a mispredict. Branch statistics built with THOR2023_BRSTAT_EN.
module thor2023_cond_resolve #(
    parameter int PCW  = 32,
    parameter int TAGW = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    thor2023_cond_resolve_if.slave    bus
);
    localparam int EW = TAGW + 3;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t         state_q, state_d;
    logic [EW-1:0]  ent_q [2];
    logic [EW-1:0]  ent_d [2];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           redirect_q, redirect_d;
    logic [PCW-1:0] redirect_pc_q, redirect_pc_d;

    logic           accept, push, pop, c, misp;
    logic [EW-1:0]  head;

    assign c    = bus.cmp_i[bus.cond_i] ^ bus.inv_i;
    assign misp = bus.br_i & (c != bus.pred_taken_i);

    // In FLUSH the stage swallows everything, so ready never depends on FIFO occupancy there.
    assign bus.in_rdy_o = (state_q == ST_FLUSH) || (cnt_q != 2'd2);
    assign accept       = bus.in_v_i & bus.in_rdy_o;
    assign push         = accept & (state_q == ST_RUN);
    assign pop          = bus.out_v_o & bus.out_rdy_i;
    assign head         = ent_q[rd_ptr_q];

    assign bus.out_v_o       = (cnt_q != 2'd0);
    assign bus.out_tag_o     = head[EW-1:3];
    assign bus.out_cond_o    = head[2];
    assign bus.out_br_o      = head[1];
    assign bus.out_misp_o    = head[0];
    assign bus.redirect_o    = redirect_q;
    assign bus.redirect_pc_o = redirect_pc_q;

    always_comb begin
        state_d       = state_q;
        ent_d         = ent_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;

        if (push) begin
            ent_d[wr_ptr_q] = {bus.tag_i, c, bus.br_i, misp};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            ST_RUN: begin
                if (push && misp) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = c ? bus.tgt_i : bus.nxt_pc_i;
                    state_d       = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (bus.flush_done_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            ent_q[0]      <= '0;
            ent_q[1]      <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            ent_q         <= ent_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

`ifdef THOR2023_BRSTAT_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_misp_q, stat_misp_d;

    always_comb begin
        stat_br_d   = stat_br_q;
        stat_misp_d = stat_misp_q;
        if (push && bus.br_i && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (push && misp && (stat_misp_q != '1)) begin
            stat_misp_d = stat_misp_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_br_q   <= '0;
            stat_misp_q <= '0;
        end else begin
            stat_br_q   <= stat_br_d;
            stat_misp_q <= stat_misp_d;
        end
    end

    assign bus.stat_br_o   = stat_br_q;
    assign bus.stat_misp_o = stat_misp_q;
`else
    assign bus.stat_br_o   = '0;
    assign bus.stat_misp_o = '0;
`endif
endmodule
